// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in word collector and its output slot.
package sipo_pkg;

    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

    // Wide enough to count a full frame including an optional trailing parity bit.
    function automatic int cnt_width(input int w);
        return $clog2(w + 2);
    endfunction

endpackage

// File: rtl/sipo_out_slot.sv
// One-entry valid/ready output register with sticky overflow on dropped words.
// Optional parity flag travels with the word when SIPO_PARITY_CHECK_EN is defined.
module sipo_out_slot
    import sipo_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
`ifdef SIPO_PARITY_CHECK_EN
    input  logic         wr_perr,
    output logic         parity_err,
`endif
    input  logic         rd_ready,
    output logic [W-1:0] dout,
    output logic         dout_valid,
    output logic         overflow
);

    out_state_t   state_q, state_d;
    logic [W-1:0] data_q, data_d;
    logic         ovf_q, ovf_d;
`ifdef SIPO_PARITY_CHECK_EN
    logic         perr_q, perr_d;
`endif

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
`ifdef SIPO_PARITY_CHECK_EN
        perr_d  = perr_q;
`endif
        case (state_q)
            OUT_EMPTY: begin
                if (wr_en) begin
                    state_d = OUT_FULL;
                    data_d  = wr_data;
`ifdef SIPO_PARITY_CHECK_EN
                    perr_d  = wr_perr;
`endif
                end
            end
            default: begin
                // A delivery on the same edge frees the slot for the new word.
                if (wr_en && rd_ready) begin
                    data_d = wr_data;
`ifdef SIPO_PARITY_CHECK_EN
                    perr_d = wr_perr;
`endif
                end else if (wr_en) begin
                    ovf_d = 1'b1;
                end else if (rd_ready) begin
                    state_d = OUT_EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= OUT_EMPTY;
            data_q  <= '0;
            ovf_q   <= 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
`ifdef SIPO_PARITY_CHECK_EN
            perr_q  <= perr_d;
`endif
        end
    end

    assign dout       = data_q;
    assign dout_valid = (state_q == OUT_FULL);
    assign overflow   = ovf_q;
`ifdef SIPO_PARITY_CHECK_EN
    assign parity_err = perr_q;
`endif

endmodule

// File: rtl/sipo_word_collector.sv
// Serial-in parallel-out collector: LSB-first bits assembled into DATA_WIDTH words.
// SIPO_PARITY_CHECK_EN appends an even-parity bit to each frame and adds parity_err.
module sipo_word_collector
    import sipo_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  din,
    input  logic                  din_en,
    input  logic                  din_sof,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  overflow,
`ifdef SIPO_PARITY_CHECK_EN
    output logic                  parity_err,
    output logic [cnt_width(DATA_WIDTH)-1:0] bit_cnt
`else
    output logic [$clog2(DATA_WIDTH+1)-1:0]  bit_cnt
`endif
);

`ifdef SIPO_PARITY_CHECK_EN
    localparam int CW = cnt_width(DATA_WIDTH);
`else
    localparam int CW = $clog2(DATA_WIDTH + 1);
`endif

    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] shifted;
    logic [DATA_WIDTH-1:0] word;
    logic                  word_done;
`ifdef SIPO_PARITY_CHECK_EN
    logic                  word_perr;
`endif

    assign shifted = {din, sreg_q[DATA_WIDTH-1:1]};

    always_comb begin
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
        word      = shifted;
        word_done = 1'b0;
`ifdef SIPO_PARITY_CHECK_EN
        word_perr = 1'b0;
`endif
        if (din_en) begin
            if (din_sof) begin
                sreg_d = {din, {(DATA_WIDTH-1){1'b0}}};
                cnt_d  = CW'(1);
`ifdef SIPO_PARITY_CHECK_EN
            end else if (cnt_q == CW'(DATA_WIDTH)) begin
                // Parity bit closes the frame; it is checked, not stored.
                word      = sreg_q;
                word_perr = ^{sreg_q, din};
                word_done = 1'b1;
                cnt_d     = '0;
`else
            end else if (cnt_q == CW'(DATA_WIDTH - 1)) begin
                sreg_d    = shifted;
                word_done = 1'b1;
                cnt_d     = '0;
`endif
            end else begin
                sreg_d = shifted;
                cnt_d  = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bit_cnt = cnt_q;

    sipo_out_slot #(
        .W(DATA_WIDTH)
    ) u_out_slot (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (word_done),
        .wr_data    (word),
`ifdef SIPO_PARITY_CHECK_EN
        .wr_perr    (word_perr),
        .parity_err (parity_err),
`endif
        .rd_ready   (dout_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .overflow   (overflow)
    );

endmodule

// File: tb/tb_sipo_word_collector.sv
// Directed bench for sipo_word_collector: expected words queued, monitor checks on handshake.
module tb_sipo_word_collector;

    localparam int DW = 16;
`ifdef SIPO_PARITY_CHECK_EN
    localparam int FRAME = DW + 1;
    localparam int CW    = $clog2(DW + 2);
`else
    localparam int FRAME = DW;
    localparam int CW    = $clog2(DW + 1);
`endif

    typedef struct packed {
        logic [DW-1:0] data;
        logic          perr;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          din = 1'b0;
    logic          din_en = 1'b0;
    logic          din_sof = 1'b0;
    logic [DW-1:0] dout;
    logic          dout_valid;
    logic          dout_ready = 1'b1;
    logic          overflow;
    logic [CW-1:0] bit_cnt;
`ifdef SIPO_PARITY_CHECK_EN
    logic          parity_err;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    sipo_word_collector #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_en     (din_en),
        .din_sof    (din_sof),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overflow   (overflow),
`ifdef SIPO_PARITY_CHECK_EN
        .parity_err (parity_err),
`endif
        .bit_cnt    (bit_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    // Monitor: every accepted word must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && dout_valid && dout_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL word_unexpected actual=0x%0h required=none", dout);
            end else begin
                exp_t e;
                e = sb.pop_front();
`ifdef SIPO_PARITY_CHECK_EN
                if (dout !== e.data || parity_err !== e.perr) begin
                    errors++;
                    $display("FAIL word actual=0x%0h/%0b required=0x%0h/%0b", dout, parity_err, e.data, e.perr);
                end else
                    $display("word 0x%0h perr=%0b delivered", dout, parity_err);
`else
                if (dout !== e.data) begin
                    errors++;
                    $display("FAIL word actual=0x%0h required=0x%0h", dout, e.data);
                end else
                    $display("word 0x%0h delivered", dout);
`endif
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic sof);
        din     = b;
        din_en  = 1'b1;
        din_sof = sof;
        step();
        din_en  = 1'b0;
        din_sof = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] w, input logic pbit);
        exp_t e;
        e.data = w;
`ifdef SIPO_PARITY_CHECK_EN
        e.perr = (^w) ^ pbit;
`else
        e.perr = pbit & 1'b0;
`endif
        sb.push_back(e);
    endtask

    // Sends one frame (data LSB first, then parity bit if enabled).
    task automatic send_word(input logic [DW-1:0] w, input logic pbit, input bit holes,
                             input bit sof_first, input bit ready_last);
        for (int i = 0; i < FRAME; i++) begin
            logic b;
            b = (i < DW) ? w[i] : pbit;
            if (ready_last && i == FRAME - 1) dout_ready = 1'b1;
            send_bit(b, sof_first && i == 0);
            if (holes && i != FRAME - 1) begin
                step();
                check("hole_bit_cnt", 32'(bit_cnt), 32'(i + 1));
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] w;
        step();
        do_reset();
        check("reset_valid", 32'(dout_valid), 32'd0);
        check("reset_cnt", 32'(bit_cnt), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);

        // Reset mid-word discards the partial word.
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        check("partial_cnt", 32'(bit_cnt), 32'd5);
        do_reset();
        check("midrst_valid", 32'(dout_valid), 32'd0);
        check("midrst_cnt", 32'(bit_cnt), 32'd0);
        check("midrst_ovf", 32'(overflow), 32'd0);
        w = 16'hBEEF;
        push(w, ^w);
        send_word(w, ^w, 1'b0, 1'b0, 1'b0);
        step();

        // Basic word with continuous din_en; valid from the final edge.
        w = 16'hA5C3;
        push(w, ^w);
        send_word(w, ^w, 1'b0, 1'b0, 1'b0);
        check("basic_valid", 32'(dout_valid), 32'd1);
        check("basic_dout", 32'(dout), 32'hA5C3);
        check("basic_cnt", 32'(bit_cnt), 32'd0);
        step();
        check("basic_retired", 32'(dout_valid), 32'd0);

        // Same word with holes between bits.
        push(w, ^w);
        send_word(w, ^w, 1'b1, 1'b0, 1'b0);
        check("holes_dout", 32'(dout), 32'hA5C3);
        step();

        // Garbage then start-of-frame realigns.
        for (int i = 0; i < 7; i++) send_bit(i[0], 1'b0);
        w = 16'h1234;
        push(w, ^w);
        send_word(w, ^w, 1'b0, 1'b1, 1'b0);
        check("realign_dout", 32'(dout), 32'h1234);
        step();

        // Backpressure: second word dropped, overflow sticks.
        dout_ready = 1'b0;
        w = 16'h0001;
        push(w, ^w);
        send_word(w, ^w, 1'b0, 1'b0, 1'b0);
        w = 16'hFFFF;
        send_word(w, ^w, 1'b0, 1'b0, 1'b0);
        check("bp_dout", 32'(dout), 32'h0001);
        check("bp_valid", 32'(dout_valid), 32'd1);
        check("bp_ovf", 32'(overflow), 32'd1);
        dout_ready = 1'b1;
        step();
        check("bp_drained", 32'(dout_valid), 32'd0);
        check("bp_ovf_sticky", 32'(overflow), 32'd1);
        do_reset();
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Handshake coinciding with completion: replace without overflow.
        dout_ready = 1'b0;
        w = 16'h0001;
        push(w, ^w);
        send_word(w, ^w, 1'b0, 1'b0, 1'b0);
        w = 16'hFFFF;
        push(w, ^w);
        send_word(w, ^w, 1'b0, 1'b0, 1'b1);
        check("swap_dout", 32'(dout), 32'hFFFF);
        check("swap_valid", 32'(dout_valid), 32'd1);
        check("swap_ovf", 32'(overflow), 32'd0);
        step();

`ifdef SIPO_PARITY_CHECK_EN
        w = 16'h0003;
        push(w, 1'b0);
        send_word(w, 1'b0, 1'b0, 1'b0, 1'b0);
        check("par_ok", 32'(parity_err), 32'd0);
        step();
        w = 16'h0007;
        push(w, 1'b0);
        send_word(w, 1'b0, 1'b0, 1'b0, 1'b0);
        check("par_err", 32'(parity_err), 32'd1);
        step();
`endif

        step();
        step();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
